// File: rtl/divisor_pkg.sv
// Shared types and constants for the divisor block.
// State encoding and default operand width.
package divisor_pkg;

  localparam int WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/divisor_if.sv
// Board-level bundle for the divisor: keys, switches, LEDs.
// master drives keys/switches, slave drives the LEDs.
interface divisor_if;

  logic [3:0] KEY;
  logic [9:0] SW;
  logic [7:0] LEDG;
  logic [7:0] LEDR;

  modport master (
    output KEY,
    output SW,
    input  LEDG,
    input  LEDR
  );

  modport slave (
    input  KEY,
    input  SW,
    output LEDG,
    output LEDR
  );

endinterface

// File: rtl/divisor_subtrator.sv
// Ripple-borrow subtractor used for the trial subtraction.
// diff_o = a_i - b_i, borrow_o set when a_i < b_i.
module subtrator #(
  parameter int N = 6
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_o
);

  // borrow ripples from LSB to MSB
  always_comb begin
    logic [N:0] bw;
    bw       = '0;
    diff_o   = '0;
    for (int i = 0; i < N; i++) begin
      diff_o[i] = a_i[i] ^ b_i[i] ^ bw[i];
      bw[i+1]   = (~a_i[i] & b_i[i])
                | (~(a_i[i] ^ b_i[i]) & bw[i]);
    end
    borrow_o = bw[N];
  end

endmodule

// File: rtl/divisor.sv
// Restoring shift-subtract divider driven by a pushbutton.
// Quotient/remainder shown on the green/red LEDs.
module divisor
  import divisor_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [7:0] LEDG,
  output logic [7:0] LEDR
);

  localparam int CW =
    (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_TOP =
    CW'(WIDTH - 1);

  logic rst_n;
  assign rst_n = KEY[0];

  logic unused_keys;
  assign unused_keys = ^KEY[3:2];

  logic [WIDTH-1:0] sw_dvd;
  logic [WIDTH-1:0] sw_dvs;
  assign sw_dvd = SW[WIDTH-1:0];
  assign sw_dvs = SW[2*WIDTH-1:WIDTH];

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   start;

  // synchronize KEY[1]; reset parks it released
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= SYNC_STAGES'({sync_q, KEY[1]});
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign start = hist_q & ~sync_q[SYNC_STAGES-1];

  state_e state_q, state_d;

  logic [WIDTH-1:0] dvd_q, dvs_q;
  logic [WIDTH-1:0] prem_q, qw_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quot_q, rem_q;
  logic             err_q;

  logic [WIDTH:0]   shifted, diff;
  logic             borrow;
  logic             qbit;
  logic [WIDTH-1:0] prem_nx;

  assign shifted = {prem_q, dvd_q[cnt_q]};

  subtrator #(
    .N (WIDTH + 1)
  ) u_sub (
    .a_i      (shifted),
    .b_i      ({1'b0, dvs_q}),
    .diff_o   (diff),
    .borrow_o (borrow)
  );

  assign qbit    = ~borrow;
  assign prem_nx = borrow ? shifted[WIDTH-1:0]
                          : diff[WIDTH-1:0];

  // state register
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: state_d = (sw_dvs == '0) ? S_DONE
                                       : S_CALC;
      S_CALC: if (cnt_q == '0) state_d = S_DONE;
      S_DONE: if (start) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  // operands, iteration and result registers
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      prem_q <= '0;
      qw_q   <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            quot_q <= '0;
            rem_q  <= '0;
            err_q  <= 1'b0;
          end
        end
        S_LOAD: begin
          dvd_q  <= sw_dvd;
          dvs_q  <= sw_dvs;
          prem_q <= '0;
          qw_q   <= '0;
          cnt_q  <= CNT_TOP;
          if (sw_dvs == '0) begin
            quot_q <= '1;
            rem_q  <= sw_dvd;
            err_q  <= 1'b1;
          end
        end
        S_CALC: begin
          prem_q <= prem_nx;
          qw_q   <= {qw_q[WIDTH-2:0], qbit};
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            quot_q <= {qw_q[WIDTH-2:0], qbit};
            rem_q  <= prem_nx;
          end
        end
        default: ;
      endcase
    end
  end

  logic busy, done;
  assign busy = (state_q == S_LOAD)
             || (state_q == S_CALC);
  assign done = (state_q == S_DONE);

  assign LEDG = {done, busy, 1'b0, quot_q};
  assign LEDR = {err_q, 2'b00, rem_q};

endmodule

// File: tb/tb_divisor.sv
// Directed bench for the divisor: latency, edge cases,
// reset abort, key hold and a full switch sweep.
module tb_divisor;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  divisor_if bus ();

  divisor dut (
    .CLOCK_50 (clk),
    .KEY      (bus.KEY),
    .SW       (bus.SW),
    .LEDG     (bus.LEDG),
    .LEDR     (bus.LEDR)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press();
    bus.KEY[1] = 1'b0;
    step(1);
    bus.KEY[1] = 1'b1;
  endtask

  initial begin
    int loads;
    logic prev;
    int dvd, dvs, q, r, e;

    bus.KEY = 4'b1110;
    bus.SW  = '0;
    step(3);
    chk("rst_ledg", bus.LEDG, 8'h00);
    chk("rst_ledr", bus.LEDR, 8'h00);

    bus.KEY[0] = 1'b1;
    step(4);
    chk("release_no_start", bus.LEDG, 8'h00);

    // 23 / 4
    bus.SW = {5'd4, 5'd23};
    press();
    step(2);
    chk("23_4_load_g", bus.LEDG, 8'h40);
    chk("23_4_load_r", bus.LEDR, 8'h00);
    step(5);
    chk("23_4_last_calc", bus.LEDG, 8'h40);
    step(1);
    chk("23_4_done_g", bus.LEDG, 8'h85);
    chk("23_4_done_r", bus.LEDR, 8'h03);

    // 31 / 1
    bus.SW = {5'd1, 5'd31};
    press();
    step(2);
    chk("31_1_load_g", bus.LEDG, 8'h40);
    chk("31_1_load_r", bus.LEDR, 8'h00);
    step(6);
    chk("31_1_done_g", bus.LEDG, 8'h9F);
    chk("31_1_done_r", bus.LEDR, 8'h00);

    // 3 / 9 started from DONE
    bus.SW = {5'd9, 5'd3};
    press();
    step(8);
    chk("3_9_done_g", bus.LEDG, 8'h80);
    chk("3_9_done_r", bus.LEDR, 8'h03);

    // 7 / 0
    bus.SW = {5'd0, 5'd7};
    press();
    step(2);
    chk("7_0_load_g", bus.LEDG, 8'h40);
    step(1);
    chk("7_0_done_g", bus.LEDG, 8'h9F);
    chk("7_0_done_r", bus.LEDR, 8'h87);

    // press and SW change during CALC ignored
    bus.SW = {5'd4, 5'd23};
    press();
    step(4);
    bus.KEY[1] = 1'b0;
    bus.SW     = {5'd3, 5'd30};
    step(2);
    bus.KEY[1] = 1'b1;
    step(2);
    chk("busy_press_g", bus.LEDG, 8'h85);
    chk("busy_press_r", bus.LEDR, 8'h03);
    step(6);
    chk("no_extra_load_g", bus.LEDG, 8'h85);

    // reset pulse in third CALC cycle
    bus.SW = {5'd4, 5'd23};
    press();
    step(5);
    bus.KEY[0] = 1'b0;
    step(1);
    chk("abort_g", bus.LEDG, 8'h00);
    chk("abort_r", bus.LEDR, 8'h00);
    bus.KEY[0] = 1'b1;
    step(3);
    chk("abort_idle_g", bus.LEDG, 8'h00);

    // key held low: one operation only
    loads = 0;
    prev  = 1'b0;
    bus.KEY[1] = 1'b0;
    repeat (100) begin
      step(1);
      if (bus.LEDG[6] && !prev) loads++;
      prev = bus.LEDG[6];
    end
    bus.KEY[1] = 1'b1;
    chk("hold_loads", 8'(loads), 8'd1);
    chk("hold_g", bus.LEDG, 8'h85);
    chk("hold_r", bus.LEDR, 8'h03);
    step(4);

    // every switch setting
    for (int v = 0; v < 1024; v++) begin
      bus.SW = 10'(v);
      press();
      step(9);
      dvd = v % 32;
      dvs = v / 32;
      if (dvs == 0) begin
        q = 31;
        r = dvd;
        e = 1;
      end else begin
        q = dvd / dvs;
        r = dvd % dvs;
        e = 0;
      end
      chk($sformatf("sweep_g_%0d", v),
          bus.LEDG, 8'(128 + q));
      chk($sformatf("sweep_r_%0d", v),
          bus.LEDR, 8'(e * 128 + r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
